// File: rtl/rsa_decrypt_datapath_if.sv
// Start/busy/done handshake and result bus for the RSA decrypt datapath.
// The master drives start/ciphertext; the slave (datapath) returns status and result.
interface rsa_decrypt_datapath_if #(
  parameter int unsigned CW = 13,
  parameter int unsigned PW = 8
);
  logic          start;
  logic [CW-1:0] ciphertext;
  logic          busy;
  logic          done;
  logic [PW-1:0] plaintext;
  logic          pt_ovf;
  logic          err;

  modport master (
    output start, ciphertext,
    input  busy, done, plaintext, pt_ovf, err
  );

  modport slave (
    input  start, ciphertext,
    output busy, done, plaintext, pt_ovf, err
  );
endinterface

// File: rtl/rsa_decrypt_datapath.sv
// Toy RSA decrypt: pt = ct^D mod N by left-to-right square-and-multiply, one mod per multiply.
// Optional macro RSA_DEC_RANGE_CHECK_EN rejects ciphertext >= N with an err/done pulse.
module rsa_decrypt_datapath #(
  parameter int unsigned N     = 3233,
  parameter int unsigned D     = 2753,
  parameter int unsigned EXP_W = 12,
  parameter int unsigned CW    = 13,
  parameter int unsigned PW    = 8
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  rsa_decrypt_datapath_if.slave bus
);

  localparam int unsigned IW    = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam int unsigned ProdW = 2 * CW;
  localparam logic [EXP_W-1:0] DExp  = EXP_W'(D);
  localparam logic [CW-1:0]    NCw   = CW'(N);
  localparam logic [ProdW-1:0] NProd = ProdW'(N);

  typedef enum logic [2:0] {StIdle, StSq, StSqMod, StMul, StMulMod} state_e;

  state_e           state_q;
  logic [CW-1:0]    acc_q;
  logic [CW-1:0]    ct_q;
  logic [ProdW-1:0] prod_q;
  logic [IW-1:0]    bit_idx_q;
  logic             busy_q;
  logic             done_q;
  logic [PW-1:0]    plaintext_q;
  logic             pt_ovf_q;
  logic             err_q;

  logic [ProdW-1:0] rem_full;
  logic [CW-1:0]    red;
  logic             end_of_bit;
  logic             last_bit;
  logic             ct_reject;

  // Constant-modulus reduction; the remainder always fits in CW bits since N < 2^CW.
  always_comb begin
    rem_full = prod_q % NProd;
    red      = rem_full[CW-1:0];
  end

  assign last_bit   = (bit_idx_q == '0);
  assign end_of_bit = ((state_q == StSqMod) && !DExp[bit_idx_q]) || (state_q == StMulMod);

`ifdef RSA_DEC_RANGE_CHECK_EN
  assign ct_reject = (bus.ciphertext >= NCw);
`else
  assign ct_reject = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      ct_q        <= '0;
      prod_q      <= '0;
      bit_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      plaintext_q <= '0;
      pt_ovf_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (ct_reject) begin
              done_q      <= 1'b1;
              err_q       <= 1'b1;
              plaintext_q <= '0;
              pt_ovf_q    <= 1'b0;
            end else begin
              ct_q      <= bus.ciphertext;
              acc_q     <= CW'(1);
              bit_idx_q <= IW'(EXP_W - 1);
              busy_q    <= 1'b1;
              err_q     <= 1'b0;
              state_q   <= StSq;
            end
          end
        end
        StSq: begin
          prod_q  <= ProdW'(acc_q) * ProdW'(acc_q);
          state_q <= StSqMod;
        end
        StSqMod: begin
          acc_q <= red;
          if (DExp[bit_idx_q]) state_q <= StMul;
        end
        StMul: begin
          prod_q  <= ProdW'(acc_q) * ProdW'(ct_q);
          state_q <= StMulMod;
        end
        StMulMod: acc_q <= red;
        default:  state_q <= StIdle;
      endcase

      // Bit retirement shared by the square-only and square+multiply paths.
      if (end_of_bit) begin
        if (last_bit) begin
          plaintext_q <= red[PW-1:0];
          pt_ovf_q    <= |red[CW-1:PW];
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end else begin
          bit_idx_q <= bit_idx_q - IW'(1);
          state_q   <= StSq;
        end
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.plaintext = plaintext_q;
  assign bus.pt_ovf    = pt_ovf_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_rsa_decrypt_datapath.sv
// Self-checking bench for rsa_decrypt_datapath against a right-to-left modexp reference model.
module tb_rsa_decrypt_datapath;
  localparam int unsigned N     = 3233;
  localparam int unsigned D     = 2753;
  localparam int unsigned EXP_W = 12;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  rsa_decrypt_datapath_if #(.CW(13), .PW(8)) ifc ();

  rsa_decrypt_datapath #(
    .N(N), .D(D), .EXP_W(EXP_W), .CW(13), .PW(8)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (ifc)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned modexp(input int unsigned ct);
    int unsigned base, r, e;
    base = ct % N;
    r    = 1;
    e    = D;
    while (e != 0) begin
      if ((e % 2) == 1) r = (r * base) % N;
      base = (base * base) % N;
      e    = e / 2;
    end
    return r;
  endfunction

  function automatic int exp_latency();
    int c;
    c = 0;
    for (int i = 0; i < EXP_W; i++) begin
      c += 2;
      if (((D >> i) & 1) == 1) c += 2;
    end
    return c;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [12:0] ct);
    ifc.start      = 1'b1;
    ifc.ciphertext = ct;
    @(posedge clk_i);
    @(negedge clk_i);
    ifc.start = 1'b0;
  endtask

  task automatic wait_done(input int poke_at, input logic [12:0] poke_ct,
                           output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = ifc.busy ? 1 : 0;
    while (!ifc.done && lat < 200) begin
      if (lat == poke_at) begin
        ifc.start      = 1'b1;
        ifc.ciphertext = poke_ct;
      end else begin
        ifc.start = 1'b0;
      end
      @(posedge clk_i);
      @(negedge clk_i);
      lat++;
      if (ifc.busy) busy_cnt++;
    end
    ifc.start = 1'b0;
  endtask

  task automatic test_reset();
    ifc.start      = 1'b0;
    ifc.ciphertext = '0;
    rst_ni         = 1'b0;
    #12;
    n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", ifc.busy); end
    n_checks++; if (ifc.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", ifc.done); end
    n_checks++; if (ifc.plaintext !== 8'd0) begin n_fail++; $display("FAIL reset_pt: got %0d expected 0", ifc.plaintext); end
    n_checks++; if (ifc.pt_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ifc.pt_ovf); end
    n_checks++; if (ifc.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", ifc.err); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_known();
    int lat, bc;
    launch(13'd2790);
    wait_done(-1, '0, lat, bc);
    n_checks++; if (lat != 34) begin n_fail++; $display("FAIL known_latency: got %0d expected 34", lat); end
    n_checks++; if (bc != 34) begin n_fail++; $display("FAIL known_busy_cycles: got %0d expected 34", bc); end
    n_checks++; if (ifc.plaintext !== 8'd65) begin n_fail++; $display("FAIL known_pt: got %0d expected 65", ifc.plaintext); end
    n_checks++; if (ifc.pt_ovf !== 1'b0) begin n_fail++; $display("FAIL known_ovf: got %b expected 0", ifc.pt_ovf); end
    n_checks++; if (ifc.err !== 1'b0) begin n_fail++; $display("FAIL known_err: got %b expected 0", ifc.err); end
    @(posedge clk_i);
    @(negedge clk_i);
    n_checks++; if (ifc.done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b expected 0", ifc.done); end
    n_checks++; if (ifc.plaintext !== 8'd65) begin n_fail++; $display("FAIL pt_held: got %0d expected 65", ifc.plaintext); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    launch(13'd0);
    wait_done(-1, '0, lat, bc);
    n_checks++; if (lat != exp_latency()) begin n_fail++; $display("FAIL b2b0_latency: got %0d expected %0d", lat, exp_latency()); end
    n_checks++; if (ifc.plaintext !== 8'd0) begin n_fail++; $display("FAIL b2b0_pt: got %0d expected 0", ifc.plaintext); end
    // Still in the done cycle: the next start must be accepted on the following edge.
    launch(13'd1);
    n_checks++; if (ifc.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b expected 1", ifc.busy); end
    wait_done(-1, '0, lat, bc);
    n_checks++; if (lat != exp_latency()) begin n_fail++; $display("FAIL b2b1_latency: got %0d expected %0d", lat, exp_latency()); end
    n_checks++; if (ifc.plaintext !== 8'd1) begin n_fail++; $display("FAIL b2b1_pt: got %0d expected 1", ifc.plaintext); end
    @(negedge clk_i);
  endtask

  task automatic test_boundary();
    int lat, bc;
    launch(13'd3232);
    wait_done(-1, '0, lat, bc);
    n_checks++; if (ifc.plaintext !== 8'hA0) begin n_fail++; $display("FAIL nm1_pt: got %0h expected a0", ifc.plaintext); end
    n_checks++; if (ifc.pt_ovf !== 1'b1) begin n_fail++; $display("FAIL nm1_ovf: got %b expected 1", ifc.pt_ovf); end
    n_checks++; if (lat != 34) begin n_fail++; $display("FAIL nm1_latency: got %0d expected 34", lat); end
    @(negedge clk_i);
  endtask

  task automatic test_ignored_start();
    int lat, bc;
    launch(13'd2790);
    wait_done(10, 13'd1234, lat, bc);
    n_checks++; if (lat != 34) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 34", lat); end
    n_checks++; if (ifc.plaintext !== 8'd65) begin n_fail++; $display("FAIL ignore_pt: got %0d expected 65", ifc.plaintext); end
    n_checks++; if (bc != 34) begin n_fail++; $display("FAIL ignore_busy_cycles: got %0d expected 34", bc); end
    @(posedge clk_i);
    @(negedge clk_i);
    n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_queue: got %b expected 0", ifc.busy); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, dones;
    launch(13'd2790);
    repeat (20) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    rst_ni = 1'b0;
    #1;
    n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", ifc.busy); end
    n_checks++; if (ifc.plaintext !== 8'd0) begin n_fail++; $display("FAIL midrst_pt: got %0d expected 0", ifc.plaintext); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    dones  = 0;
    repeat (40) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (ifc.done || ifc.busy) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL midrst_activity: got %0d expected 0", dones); end
    launch(13'd2790);
    wait_done(-1, '0, lat, bc);
    n_checks++; if (ifc.plaintext !== 8'd65) begin n_fail++; $display("FAIL midrst_redo_pt: got %0d expected 65", ifc.plaintext); end
    n_checks++; if (lat != 34) begin n_fail++; $display("FAIL midrst_redo_latency: got %0d expected 34", lat); end
    @(negedge clk_i);
  endtask

  task automatic test_out_of_range();
    int lat, bc, exp_lat, exp_bc;
    logic [12:0] ct;
    int unsigned r;
    logic exp_err;
    for (int i = 0; i < 3; i++) begin
      ct = (i == 0) ? 13'd3233 : 13'($urandom_range(8191, N));
`ifdef RSA_DEC_RANGE_CHECK_EN
      r       = 0;
      exp_lat = 0;
      exp_bc  = 0;
      exp_err = 1'b1;
`else
      r       = modexp(ct);
      exp_lat = exp_latency();
      exp_bc  = exp_latency();
      exp_err = 1'b0;
`endif
      launch(ct);
      wait_done(-1, '0, lat, bc);
      n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL oor_latency ct=%0d: got %0d expected %0d", ct, lat, exp_lat); end
      n_checks++; if (bc != exp_bc) begin n_fail++; $display("FAIL oor_busy ct=%0d: got %0d expected %0d", ct, bc, exp_bc); end
      n_checks++; if (ifc.err !== exp_err) begin n_fail++; $display("FAIL oor_err ct=%0d: got %b expected %b", ct, ifc.err, exp_err); end
      n_checks++; if (ifc.plaintext !== 8'(r % 256)) begin n_fail++; $display("FAIL oor_pt ct=%0d: got %0d expected %0d", ct, ifc.plaintext, r % 256); end
      n_checks++; if (ifc.pt_ovf !== (r > 255)) begin n_fail++; $display("FAIL oor_ovf ct=%0d: got %b expected %b", ct, ifc.pt_ovf, (r > 255)); end
      @(negedge clk_i);
    end
    launch(13'd2790);
    wait_done(-1, '0, lat, bc);
    n_checks++; if (ifc.err !== 1'b0) begin n_fail++; $display("FAIL oor_err_clear: got %b expected 0", ifc.err); end
    n_checks++; if (ifc.plaintext !== 8'd65) begin n_fail++; $display("FAIL oor_after_pt: got %0d expected 65", ifc.plaintext); end
    @(negedge clk_i);
  endtask

  task automatic test_random();
    int lat, bc;
    logic [12:0] ct;
    int unsigned r;
    for (int i = 0; i < 8; i++) begin
      ct = 13'($urandom_range(N - 1, 0));
      r  = modexp(ct);
      launch(ct);
      wait_done(-1, '0, lat, bc);
      n_checks++; if (lat != exp_latency()) begin n_fail++; $display("FAIL rand_latency ct=%0d: got %0d expected %0d", ct, lat, exp_latency()); end
      n_checks++; if (ifc.plaintext !== 8'(r % 256)) begin n_fail++; $display("FAIL rand_pt ct=%0d: got %0d expected %0d", ct, ifc.plaintext, r % 256); end
      n_checks++; if (ifc.pt_ovf !== (r > 255)) begin n_fail++; $display("FAIL rand_ovf ct=%0d: got %b expected %b", ct, ifc.pt_ovf, (r > 255)); end
      n_checks++; if (ifc.err !== 1'b0) begin n_fail++; $display("FAIL rand_err ct=%0d: got %b expected 0", ct, ifc.err); end
      @(negedge clk_i);
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_back_to_back();
    test_boundary();
    test_ignored_start();
    test_reset_mid();
    test_out_of_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
